// File: rtl/adc_avg_hist.sv
// Per-lane ADC statistics: windowed sum, average and center/side histogram of one
// interleaved ADC lane. Windows of 2**Navg samples run back-to-back while en is high.
module adc_avg_hist #(
  parameter int unsigned Nadc   = 8,
  parameter int unsigned Nrange = 4
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         en,
  input  logic [Nadc-1:0]              din,
  input  logic [Nrange-1:0]            Navg,
  input  logic [Nrange-1:0]            Nbin,
  output logic [Nadc+2**Nrange-1:0]    sum_out,
  output logic [Nadc-1:0]              avg_out,
  output logic [2**Nrange-1:0]         hist_center,
  output logic [2**Nrange-1:0]         hist_side,
  output logic                         update
);

  localparam int unsigned Cw = 2**Nrange;
  localparam int unsigned Sw = Nadc + Cw;
  // Deviation width: wide enough for din - avg_ref and for 3W+1.
  localparam int unsigned Dw = (Nadc + 2 > Nrange + 3) ? Nadc + 2 : Nrange + 3;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e                  r_state, w_state_d;
  logic [Nrange-1:0]       r_navg, r_nbin;
  logic signed [Sw-1:0]    r_acc;
  logic [Cw-1:0]           r_cnt;
  logic [Cw-1:0]           r_cnt_c, r_cnt_l, r_cnt_r;

  logic signed [Sw-1:0]    w_din_ext, w_sum, w_sum_shift;
  logic signed [Dw-1:0]    w_d, w_w, w_w3;
  logic                    w_c, w_l, w_r;
  logic [Cw-1:0]           w_len_m1;
  logic                    w_last, w_load;
  logic [Cw-1:0]           w_cnt_c_nx, w_cnt_l_nx, w_cnt_r_nx;
  logic [Cw:0]             w_side_sum;

  // Datapath for the current sample: running sum, bin classification, window end.
  always_comb begin
    w_din_ext   = $signed({{Cw{din[Nadc-1]}}, din});
    w_sum       = r_acc + w_din_ext;
    w_sum_shift = w_sum >>> r_navg;
    // The reference is always the last published average (0 after reset).
    w_d  = $signed({{(Dw-Nadc){din[Nadc-1]}}, din})
         - $signed({{(Dw-Nadc){avg_out[Nadc-1]}}, avg_out});
    w_w  = $signed({{(Dw-Nrange){1'b0}}, r_nbin});
    w_w3 = (w_w <<< 1) + w_w + Dw'(1);
    w_c  = (w_d >= -w_w) && (w_d <= w_w);
    w_l  = (w_d >= -w_w3) && (w_d < -w_w);
    w_r  = (w_d > w_w) && (w_d <= w_w3);
    w_cnt_c_nx = r_cnt_c + Cw'(w_c);
    w_cnt_l_nx = r_cnt_l + Cw'(w_l);
    w_cnt_r_nx = r_cnt_r + Cw'(w_r);
    w_side_sum = {1'b0, w_cnt_l_nx} + {1'b0, w_cnt_r_nx};
    w_len_m1   = ~({Cw{1'b1}} << r_navg);
    w_last     = (r_cnt == w_len_m1);
    w_load     = (r_state == StAccum) && en && w_last;
  end

  // Next-state: any en=0 returns to idle, discarding the partial window.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (en) w_state_d = StAccum;
      StAccum: if (!en) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Accumulators, window control and published outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_navg      <= '0;
      r_nbin      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_cnt_c     <= '0;
      r_cnt_l     <= '0;
      r_cnt_r     <= '0;
      sum_out     <= '0;
      avg_out     <= '0;
      hist_center <= '0;
      hist_side   <= '0;
      update      <= 1'b0;
    end else begin
      update <= 1'b0;
      if (r_state == StIdle) begin
        if (en) begin
          r_navg  <= Navg;
          r_nbin  <= Nbin;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_cnt_c <= '0;
          r_cnt_l <= '0;
          r_cnt_r <= '0;
        end
      end else if (en) begin
        if (w_load) begin
          // Publish including this final sample; next window starts on the next edge.
          sum_out     <= w_sum;
          avg_out     <= w_sum_shift[Nadc-1:0];
          hist_center <= w_cnt_c_nx;
          hist_side   <= w_side_sum[Cw:1];
          update      <= 1'b1;
          r_navg      <= Navg;
          r_nbin      <= Nbin;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_cnt_c     <= '0;
          r_cnt_l     <= '0;
          r_cnt_r     <= '0;
        end else begin
          r_acc   <= w_sum;
          r_cnt   <= r_cnt + Cw'(1'b1);
          r_cnt_c <= w_cnt_c_nx;
          r_cnt_l <= w_cnt_l_nx;
          r_cnt_r <= w_cnt_r_nx;
        end
      end
    end
  end

endmodule
